mpu_input_ctrl: RTL and testbench
=================================

// Module: mpu_input_ctrl
// PURPOSE
// - Input front-end for the 4-bit simplified microprocessor. Debounces board switches/buttons and
//   turns them into the operand bank, carry-in and single-cycle step strobe that feed mpu.
// - Fills all NUM_OPS operand slots (incl. m_i[2]) from one WIDTH-bit switch bank via a load button.
// - Dual of the display path: display converts mpu state to user output; this block converts user
//   input to mpu stimulus.
// PARAMETERS
// - WIDTH         4           operand width, bits
// - NUM_OPS       3           operand slots; sel wraps NUM_OPS-1 -> 0
// - DEB_CYCLES    1_000_000   consecutive stable cycles to accept a level change (10 ms @ 100 MHz)
// - REPEAT_CYCLES 25_000_000  auto-repeat period (only with AUTO_STEP_EN)
// PORTS
// - clk          input   1                system clock; all state on posedge
// - reset        input   1                synchronous, active-high
// - sw_i         input   WIDTH            raw operand switches (async)
// - cin_sw_i     input   1                raw carry-in switch (async)
// - btn_load_i   input   1                raw load button, active-high (async)
// - btn_step_i   input   1                raw step button, active-high (async)
// - m_o          output  [WIDTH-1:0] x [NUM_OPS-1:0]  operand bank, unpacked, to mpu m_i
// - cin_o        output  1                debounced carry-in
// - sel_o        output  $clog2(NUM_OPS)  slot written by next load
// - step_o       output  1                one-cycle advance strobe to mpu
// BEHAVIOUR
// - Reset: m_o all 0, cin_o 0, sel_o 0, step_o 0; sync flops, debounce counters, stable levels 0;
//   button FSMs -> IDLE. Reset mid-debounce or mid-press drops all progress; a button held through
//   reset deassertion must be released and re-pressed to fire.
// - Sync: every raw input passes a 2-flop synchronizer before any other logic.
// - Debounce per input (sw_i bits, cin_sw_i, both buttons): counter counts consecutive cycles where
//   synced value != stable value; any cycle of equality clears it; stable value flips on the cycle
//   count reaches DEB_CYCLES. Pulses shorter than DEB_CYCLES are ignored.
// - Button FSM (load, step each): IDLE --stable=1--> FIRE (1 cycle, internal press pulse) -> HELD;
//   HELD --stable=0--> IDLE. Exactly one pulse per press, regardless of hold time.
// - Latency: raw edge held steady -> press pulse in cycle 2+DEB_CYCLES+1 after the edge.
// - Load pulse: m_o[sel_o] <= debounced sw_i next cycle; other slots unchanged;
//   sel_o <= (sel_o==NUM_OPS-1) ? 0 : sel_o+1 in the same cycle.
// - Step pulse: step_o high exactly one cycle, registered, one cycle after the pulse.
// - Same-cycle load+step: load commits first; step_o is delayed one extra cycle so mpu samples
//   the updated m_o. No pulse is lost or merged.
// - Step pending (delayed) when another step pulse arrives: impossible by FSM (>=DEB_CYCLES apart);
//   DEB_CYCLES must be >=2, enforced by elaboration-time assertion.
// - cin_o follows debounced cin_sw_i continuously; no handshake.
// CONFIGURATION
// - AUTO_STEP_EN defined: in HELD, step FSM counts cycles; after REPEAT_CYCLES it fires another
//   step pulse and reloads the count, repeating every REPEAT_CYCLES until release. Load never repeats.
// - AUTO_STEP_EN undefined: no repeat counter synthesized; one step per press.
// TESTING (bench DEB_CYCLES=4, REPEAT_CYCLES=10, NUM_OPS=3)
// - Reset: assert reset 2 cycles with buttons high -> all outputs 0; no step_o until release+re-press.
// - Glitch: btn_step_i high 3 cycles -> step_o never asserts; held 8 cycles -> exactly one
//   step_o pulse, 8 cycles after rise.
// - Load sweep: sw_i=4'hA,4'h5,4'hF,4'h3 with four loads -> m_o={F,5,A} after 3 loads,
//   sel_o 0->1->2->0, 4th load gives m_o[0]=3.
// - Simultaneous: load+step rise same cycle, sw_i=4'h7, sel_o=1 -> m_o[1]=7 one cycle before
//   step_o is high.
// - cin: cin_sw_i 0->1 -> cin_o=1 after 2+4 cycles; 2-cycle bounce back to 0 ignored.
// - AUTO_STEP_EN: hold step 40 cycles -> first pulse, then pulses every 10 cycles until release;
//   without macro, exactly one pulse.

Source files
------------

// File: rtl/mpu_input_ctrl_if.sv
// Signal bundle between the board-side switches/buttons and the mpu input front-end.
// The board side (master) drives the raw inputs; the front-end (slave) drives mpu stimulus.
interface mpu_input_ctrl_if #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 3
);
  localparam int SEL_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

  logic [WIDTH-1:0] sw_i;
  logic             cin_sw_i;
  logic             btn_load_i;
  logic             btn_step_i;
  logic [WIDTH-1:0] m_o [NUM_OPS-1:0];
  logic             cin_o;
  logic [SEL_W-1:0] sel_o;
  logic             step_o;

  modport master (
    output sw_i, cin_sw_i, btn_load_i, btn_step_i,
    input  m_o, cin_o, sel_o, step_o
  );

  modport slave (
    input  sw_i, cin_sw_i, btn_load_i, btn_step_i,
    output m_o, cin_o, sel_o, step_o
  );
endinterface

// File: rtl/mpu_input_ctrl.sv
// Input front-end for the 4-bit mpu: synchronizes and debounces switches/buttons into operands,
// carry-in and a one-cycle step strobe. Define AUTO_STEP_EN for auto-repeat stepping while held.
//
// state | meaning
// IDLE  | button released, waiting for a debounced press
// FIRE  | one-cycle internal press pulse
// HELD  | waiting for debounced release (step: auto-repeat timing when enabled)
module mpu_input_ctrl #(
  parameter int WIDTH         = 4,
  parameter int NUM_OPS       = 3,
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int REPEAT_CYCLES = 25_000_000
) (
  input logic           clk,
  input logic           reset,
  mpu_input_ctrl_if.slave bus
);
  localparam int SEL_W    = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam int NIN      = WIDTH + 3;
  localparam int IDX_CIN  = WIDTH;
  localparam int IDX_LOAD = WIDTH + 1;
  localparam int IDX_STEP = WIDTH + 2;
  localparam int DW       = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LOAD = DW'(DEB_CYCLES - 1);

  generate
    if (DEB_CYCLES < 2) begin : g_bad_deb
      $error("mpu_input_ctrl: DEB_CYCLES must be >= 2");
    end
    if (NUM_OPS < 2) begin : g_bad_ops
      $error("mpu_input_ctrl: NUM_OPS must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_FIRE, ST_HELD} btn_state_t;

  logic [NIN-1:0]   raw, sync1, sync2, stable;
  logic [DW-1:0]    deb_cnt [NIN];
  logic [1:0]       sync_vld;
  logic             arm_load, arm_step;
  btn_state_t       ld_state, ld_next, st_state, st_next;
  logic             ld_fire, st_fire, step_pend, step_q;
  logic [WIDTH-1:0] m_q [NUM_OPS-1:0];
  logic [SEL_W-1:0] sel_q;

  assign raw = {bus.btn_step_i, bus.btn_load_i, bus.cin_sw_i, bus.sw_i};

  // Each down-counter reloads on agreement; the level flips when it expires while still differing.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      for (int i = 0; i < NIN; i++) deb_cnt[i] <= DEB_LOAD;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < NIN; i++) begin
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= DEB_LOAD;
        end else if (deb_cnt[i] == '0) begin
          stable[i]  <= ~stable[i];
          deb_cnt[i] <= DEB_LOAD;
        end else begin
          deb_cnt[i] <= deb_cnt[i] - DW'(1);
        end
      end
    end
  end

  // A button only arms after a post-reset low sample, so one held through reset cannot fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_vld <= '0;
      arm_load <= 1'b0;
      arm_step <= 1'b0;
    end else begin
      sync_vld <= {sync_vld[0], 1'b1};
      arm_load <= arm_load | (sync_vld[1] & ~sync2[IDX_LOAD]);
      arm_step <= arm_step | (sync_vld[1] & ~sync2[IDX_STEP]);
    end
  end

`ifdef AUTO_STEP_EN
  localparam int RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] RPT_LOAD = RW'(REPEAT_CYCLES - 2);
  logic [RW-1:0] rpt_cnt;

  generate
    if (REPEAT_CYCLES < 2) begin : g_bad_rpt
      $error("mpu_input_ctrl: REPEAT_CYCLES must be >= 2");
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || st_state != ST_HELD) rpt_cnt <= RPT_LOAD;
    else if (rpt_cnt != '0)           rpt_cnt <= rpt_cnt - RW'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_state <= ST_IDLE;
      st_state <= ST_IDLE;
    end else begin
      ld_state <= ld_next;
      st_state <= st_next;
    end
  end

  always_comb begin
    ld_next = ld_state;
    case (ld_state)
      ST_IDLE: if (stable[IDX_LOAD]) ld_next = arm_load ? ST_FIRE : ST_HELD;
      ST_FIRE: ld_next = ST_HELD;
      ST_HELD: if (!stable[IDX_LOAD]) ld_next = ST_IDLE;
      default: ld_next = ST_IDLE;
    endcase
  end

  always_comb begin
    st_next = st_state;
    case (st_state)
      ST_IDLE: if (stable[IDX_STEP]) st_next = arm_step ? ST_FIRE : ST_HELD;
      ST_FIRE: st_next = ST_HELD;
      ST_HELD: begin
        if (!stable[IDX_STEP]) st_next = ST_IDLE;
`ifdef AUTO_STEP_EN
        else if (arm_step && rpt_cnt == '0) st_next = ST_FIRE;
`endif
      end
      default: st_next = ST_IDLE;
    endcase
  end

  assign ld_fire = (ld_state == ST_FIRE);
  assign st_fire = (st_state == ST_FIRE);

  // A step coinciding with a load is held back one cycle so mpu sees the new operand.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_OPS; i++) m_q[i] <= '0;
      sel_q     <= '0;
      step_q    <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      if (ld_fire) begin
        for (int i = 0; i < NUM_OPS; i++) begin
          if (SEL_W'(i) == sel_q) m_q[i] <= stable[WIDTH-1:0];
        end
        sel_q <= (sel_q == SEL_W'(NUM_OPS - 1)) ? '0 : sel_q + SEL_W'(1);
      end
      step_q    <= (st_fire & ~ld_fire) | step_pend;
      step_pend <= st_fire & ld_fire;
    end
  end

  assign bus.m_o    = m_q;
  assign bus.sel_o  = sel_q;
  assign bus.cin_o  = stable[IDX_CIN];
  assign bus.step_o = step_q;
endmodule

// File: tb/tb_mpu_input_ctrl.sv
// Bench for mpu_input_ctrl: directed scenarios plus random input activity, every cycle
// compared against a sliding-window reference model of sync, debounce, press and step rules.
module tb_mpu_input_ctrl;
  localparam int WIDTH = 4, NUM_OPS = 3, DEB = 4, REP = 10;
  localparam int NIN = WIDTH + 3, IC = WIDTH, IL = WIDTH + 1, IS = WIDTH + 2;
`ifdef AUTO_STEP_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [NIN-1:0] drv;
  always #5 clk = ~clk;

  mpu_input_ctrl_if #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS)) bus ();
  assign bus.sw_i       = drv[WIDTH-1:0];
  assign bus.cin_sw_i   = drv[IC];
  assign bus.btn_load_i = drv[IL];
  assign bus.btn_step_i = drv[IS];

  mpu_input_ctrl #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .DEB_CYCLES(DEB), .REPEAT_CYCLES(REP))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0, checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [NIN-1:0]   hist[$];
  logic [NIN-1:0]   win[$];
  logic [NIN-1:0]   mstab, mstab_p;
  logic [WIDTH-1:0] mm [NUM_OPS];
  bit marm_l, marm_s, s_held, mstep;
  bit fl_p1, fl_p2, fs_p1, fs_p2;
  int msel, cyc, last_sfire;

  // Watchers
  int tcount, pulses, first_step;

  task automatic model_edge();
    logic [NIN-1:0] cons, nst;
    bit fl, fs, all;
    if (reset) begin
      hist.delete();
      win.delete();
      for (int j = 0; j < DEB; j++) win.push_front('0);
      mstab = '0; mstab_p = '0;
      for (int k = 0; k < NUM_OPS; k++) mm[k] = '0;
      marm_l = 0; marm_s = 0; s_held = 0; mstep = 0;
      fl_p1 = 0; fl_p2 = 0; fs_p1 = 0; fs_p2 = 0;
      msel = 0; cyc = 0; last_sfire = -1000;
      return;
    end
    cyc++;
    hist.push_front(drv);
    if (hist.size() > 3) void'(hist.pop_back());
    cons = (hist.size() >= 3) ? hist[2] : '0;
    fl = marm_l && mstab[IL] && !mstab_p[IL];
    fs = (marm_s && mstab[IS] && !mstab_p[IS]) ||
         (AUTO && marm_s && s_held && (cyc - last_sfire == REP));
    mstep = (fs_p1 && !fl_p1) || (fs_p2 && fl_p2);
    if (fl_p1) begin
      mm[msel] = mstab[WIDTH-1:0];
      msel = (msel + 1) % NUM_OPS;
    end
    win.push_front(cons);
    if (win.size() > DEB) void'(win.pop_back());
    nst = mstab;
    for (int i = 0; i < NIN; i++) begin
      all = 1;
      foreach (win[j]) if (win[j][i] == mstab[i]) all = 0;
      if (all) nst[i] = ~mstab[i];
    end
    if (hist.size() >= 3) begin
      if (!cons[IL]) marm_l = 1;
      if (!cons[IS]) marm_s = 1;
    end
    if (fs) begin
      last_sfire = cyc;
      s_held = 1;
    end else begin
      s_held = s_held && nst[IS];
    end
    fl_p2 = fl_p1; fl_p1 = fl; fs_p2 = fs_p1; fs_p1 = fs;
    mstab_p = mstab; mstab = nst;
  endtask

  task automatic compare_all();
    for (int i = 0; i < NUM_OPS; i++) check($sformatf("m_o[%0d]", i), bus.m_o[i], mm[i]);
    check("sel_o", bus.sel_o, msel);
    check("cin_o", bus.cin_o, mstab[IC]);
    check("step_o", bus.step_o, mstep);
    if (bus.step_o === 1'b1) begin
      pulses++;
      if (first_step < 0) first_step = tcount;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    tcount++;
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic mark();
    tcount = 0; pulses = 0; first_step = -1;
  endtask

  int hold [NIN];
  int m_tick, s_tick, cin_tick, cin_low;

  initial begin
    // Reset with both buttons held: nothing may fire until release and re-press
    drv = '0;
    drv[IL] = 1'b1;
    drv[IS] = 1'b1;
    reset = 1'b1;
    mark();
    idle(2);
    check("rst_sel", bus.sel_o, 0);
    check("rst_step", bus.step_o, 0);
    check("rst_cin", bus.cin_o, 0);
    for (int i = 0; i < NUM_OPS; i++) check($sformatf("rst_m[%0d]", i), bus.m_o[i], 0);
    reset = 1'b0;
    mark();
    idle(20);
    check("held_thru_reset_steps", pulses, 0);
    check("held_thru_reset_sel", bus.sel_o, 0);
    drv[IL] = 1'b0;
    drv[IS] = 1'b0;
    idle(10);
    drv[IS] = 1'b1;
    mark();
    idle(10);
    drv[IS] = 1'b0;
    idle(12);
    check("repress_steps", pulses, 1);

    // Glitch shorter than the debounce window, then a valid 8-cycle press
    drv[IS] = 1'b1;
    mark();
    idle(3);
    drv[IS] = 1'b0;
    idle(10);
    check("glitch_steps", pulses, 0);
    drv[IS] = 1'b1;
    mark();
    idle(8);
    drv[IS] = 1'b0;
    idle(12);
    check("press8_steps", pulses, 1);
    check("press8_latency", first_step, 8);

    // Load sweep across all slots with wrap
    begin
      logic [WIDTH-1:0] vals [4];
      int sel_exp [4];
      vals = '{4'hA, 4'h5, 4'hF, 4'h3};
      sel_exp = '{1, 2, 0, 1};
      for (int k = 0; k < 4; k++) begin
        drv[WIDTH-1:0] = vals[k];
        idle(8);
        drv[IL] = 1'b1;
        idle(8);
        drv[IL] = 1'b0;
        idle(8);
        check($sformatf("sweep_sel%0d", k), bus.sel_o, sel_exp[k]);
        if (k == 2) begin
          check("sweep_m0", bus.m_o[0], 4'hA);
          check("sweep_m1", bus.m_o[1], 4'h5);
          check("sweep_m2", bus.m_o[2], 4'hF);
        end
      end
      check("sweep_m0_wrap", bus.m_o[0], 4'h3);
    end

    // Simultaneous load and step into slot 1
    drv[WIDTH-1:0] = 4'h7;
    idle(8);
    drv[IL] = 1'b1;
    drv[IS] = 1'b1;
    mark();
    m_tick = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (m_tick < 0 && bus.m_o[1] === 4'h7) m_tick = tcount;
    end
    drv[IL] = 1'b0;
    drv[IS] = 1'b0;
    idle(12);
    s_tick = first_step;
    check("simul_m_tick", m_tick, 8);
    check("simul_step_tick", s_tick, 9);
    check("simul_steps", pulses, 1);

    // Carry-in level and a short bounce
    drv[IC] = 1'b1;
    mark();
    cin_tick = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cin_tick < 0 && bus.cin_o === 1'b1) cin_tick = tcount;
    end
    check("cin_latency", cin_tick, 6);
    drv[IC] = 1'b0;
    cin_low = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) drv[IC] = 1'b1;
      tick();
      if (bus.cin_o !== 1'b1) cin_low++;
    end
    check("cin_bounce", cin_low, 0);

    // Long hold: one pulse, or a pulse every REP cycles with auto-repeat
    drv[IS] = 1'b1;
    mark();
    idle(40);
    drv[IS] = 1'b0;
    idle(15);
    check("long_hold_steps", pulses, AUTO ? 4 : 1);
    check("long_hold_first", first_step, 8);

    // Random activity with occasional reset
    for (int i = 0; i < NIN; i++) hold[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NIN; i++) begin
        if (hold[i] == 0) begin
          drv[i] = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, (i >= IL) ? 16 : 10);
        end else begin
          hold[i]--;
        end
      end
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
